// File: rtl/crq_tag_release_pkg.sv
// Shared definitions for the tag-release recycler and the criq free list.
// Tag width, depths, reserved tag and the initial free-tag table.
package crq_tag_release_pkg;

  localparam int unsigned TAGWIDE  = 5;
  localparam int unsigned RELDEEP  = 8;
  localparam int unsigned CNTWIDE  = 4;
  localparam int unsigned PTRWIDE  = $clog2(RELDEEP);
  localparam int unsigned FREEDEEP = 8;

  typedef logic [TAGWIDE-1:0] tag_t;

  // Architectural r0 mapping; never recycled.
  localparam tag_t RSVD_TAG = '0;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } rel_slot_t;

  // Free list powers up holding tags 3,7,...,31.
  function automatic tag_t init_free_tag(input int unsigned idx);
    return TAGWIDE'(4 * idx + 3);
  endfunction

endpackage

// File: rtl/crq_tag_release_if.sv
// Commit-side release bus plus free-list write port of the tag recycler.
interface crq_tag_release_if;
  import crq_tag_release_pkg::*;

  logic                RetValid0;
  tag_t                RetTag0;
  logic                RetValid1;
  tag_t                RetTag1;
  logic                RetReady;
  logic                RelClean;
  logic                CriqFull;
  logic                CriqWable;
  tag_t                CriqDin;
  logic                RelEmpty;
  logic [CNTWIDE-1:0]  RelCount;

  modport master (
    output RetValid0, RetTag0, RetValid1, RetTag1, RelClean, CriqFull,
    input  RetReady, CriqWable, CriqDin, RelEmpty, RelCount
  );

  modport slave (
    input  RetValid0, RetTag0, RetValid1, RetTag1, RelClean, CriqFull,
    output RetReady, CriqWable, CriqDin, RelEmpty, RelCount
  );

endinterface

// File: rtl/crq_tag_release_rel_fifo.sv
// Two-write / one-read circular buffer of released tags (head/tail/count).
module crq_tag_release_rel_fifo
  import crq_tag_release_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic [1:0]         i_wr_n,
  input  tag_t               i_wr_tag0,
  input  tag_t               i_wr_tag1,
  input  logic               i_rd,
  output tag_t               o_rd_tag,
  output logic [CNTWIDE-1:0] o_count,
  output logic [CNTWIDE-1:0] o_count_nxt
);

  tag_t               r_buf [RELDEEP];
  logic [PTRWIDE-1:0] r_head;
  logic [PTRWIDE-1:0] r_tail;
  logic [CNTWIDE-1:0] r_count;
  logic [PTRWIDE-1:0] w_tail1;

  assign w_tail1     = r_tail + PTRWIDE'(1);
  assign o_rd_tag    = r_buf[r_head];
  assign o_count     = r_count;

  always_comb begin
    o_count_nxt = r_count;
    if (i_clr) begin
      o_count_nxt = '0;
    end else begin
      o_count_nxt = r_count + CNTWIDE'(i_wr_n) - CNTWIDE'(i_rd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTRWIDE'(i_rd);
      r_tail  <= r_tail + PTRWIDE'(i_wr_n);
      r_count <= o_count_nxt;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (!i_clr) begin
      if (i_wr_n != 2'd0) r_buf[r_tail]  <= i_wr_tag0;
      if (i_wr_n == 2'd2) r_buf[w_tail1] <= i_wr_tag1;
    end
  end

endmodule

// File: rtl/crq_tag_release.sv
// Retire-side recycler: buffers up to two released tags per cycle and feeds the criq one per cycle.
// Optional RELQ_ZERO_FILTER_EN drops releases of the reserved tag 0 at enqueue.
module crq_tag_release
  import crq_tag_release_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  crq_tag_release_if.slave   rel
);

  logic               w_accept;
  logic               w_keep0;
  logic               w_keep1;
  rel_slot_t          w_slot0;
  rel_slot_t          w_slot1;
  logic [1:0]         w_wr_n;
  tag_t               w_wr_tag0;
  tag_t               w_wr_tag1;
  logic               w_drain;
  tag_t               w_rd_tag;
  logic [CNTWIDE-1:0] w_count;
  logic [CNTWIDE-1:0] w_count_nxt;
  logic               w_wable_nxt;

  logic               r_wable;
  tag_t               r_din;
  logic               r_ready;
  logic               r_empty;

`ifdef RELQ_ZERO_FILTER_EN
  assign w_keep0 = (rel.RetTag0 != RSVD_TAG);
  assign w_keep1 = (rel.RetTag1 != RSVD_TAG);
`else
  assign w_keep0 = 1'b1;
  assign w_keep1 = 1'b1;
`endif

  // Clean outranks everything; valids while not ready are ignored.
  assign w_accept = r_ready && !rel.RelClean;
  assign w_slot0  = '{valid: rel.RetValid0 && w_accept && w_keep0, tag: rel.RetTag0};
  assign w_slot1  = '{valid: rel.RetValid1 && w_accept && w_keep1, tag: rel.RetTag1};

  // Compact surviving slots so a lone tag always lands at tail.
  always_comb begin
    w_wr_n    = 2'd0;
    w_wr_tag0 = w_slot0.tag;
    w_wr_tag1 = w_slot1.tag;
    if (w_slot0.valid && w_slot1.valid) begin
      w_wr_n = 2'd2;
    end else if (w_slot0.valid) begin
      w_wr_n = 2'd1;
    end else if (w_slot1.valid) begin
      w_wr_n    = 2'd1;
      w_wr_tag0 = w_slot1.tag;
    end
  end

  assign w_drain     = !rel.RelClean && (w_count != '0) && !rel.CriqFull;
  assign w_wable_nxt = w_drain;

  crq_tag_release_rel_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (rel.RelClean),
    .i_wr_n      (w_wr_n),
    .i_wr_tag0   (w_wr_tag0),
    .i_wr_tag1   (w_wr_tag1),
    .i_rd        (w_drain),
    .o_rd_tag    (w_rd_tag),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt)
  );

  // Free-list write register; ready/empty are registered from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wable <= 1'b0;
      r_din   <= '0;
      r_ready <= 1'b1;
      r_empty <= 1'b1;
    end else begin
      r_wable <= w_wable_nxt;
      if (w_drain) r_din <= w_rd_tag;
      r_ready <= (w_count_nxt <= CNTWIDE'(RELDEEP - 2));
      r_empty <= (w_count_nxt == '0) && !w_wable_nxt;
    end
  end

  assign rel.CriqWable = r_wable;
  assign rel.CriqDin   = r_din;
  assign rel.RetReady  = r_ready;
  assign rel.RelEmpty  = r_empty;
  assign rel.RelCount  = w_count;

endmodule

// File: tb/tb_crq_tag_release.sv
// Self-checking bench for crq_tag_release: vector table plus wrap, filter and async-reset sequences.
module tb_crq_tag_release;
  import crq_tag_release_pkg::*;

  typedef struct {
    logic       v0;
    logic [4:0] t0;
    logic       v1;
    logic [4:0] t1;
    logic       full;
    logic       clean;
    logic       wable;
    logic [4:0] din;
    logic [3:0] cnt;
    logic       rdy;
    logic       emp;
  } vec_t;

  localparam int NVEC = 28;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  crq_tag_release_if rel_if ();

  crq_tag_release dut (
    .clk (clk),
    .rst (rst),
    .rel (rel_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mv(input int v0, input int t0, input int v1, input int t1,
                              input int f, input int c, input int w, input int d,
                              input int n, input int r, input int e);
    vec_t x;
    x.v0 = 1'(v0); x.t0 = 5'(t0); x.v1 = 1'(v1); x.t1 = 5'(t1);
    x.full = 1'(f); x.clean = 1'(c);
    x.wable = 1'(w); x.din = 5'(d); x.cnt = 4'(n); x.rdy = 1'(r); x.emp = 1'(e);
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v0, input int t0, input int v1, input int t1,
                       input int f, input int c);
    rel_if.RetValid0 = 1'(v0);
    rel_if.RetTag0   = 5'(t0);
    rel_if.RetValid1 = 1'(v1);
    rel_if.RetTag1   = 5'(t1);
    rel_if.CriqFull  = 1'(f);
    rel_if.RelClean  = 1'(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int w, input int d, input int n,
                         input int r, input int e);
    chk({tag, "_wable"}, int'(rel_if.CriqWable), w);
    chk({tag, "_din"},   int'(rel_if.CriqDin),   d);
    chk({tag, "_count"}, int'(rel_if.RelCount),  n);
    chk({tag, "_ready"}, int'(rel_if.RetReady),  r);
    chk({tag, "_empty"}, int'(rel_if.RelEmpty),  e);
  endtask

  initial begin
    vec_t   tbl [NVEC];
    tag_t   expq [$];
    tag_t   got  [$];
    tag_t   exp_tag;
    int     sent;
    int     cyc;

    checks   = 0;
    failures = 0;
    drive(0, 0, 0, 0, 0, 0);

    // reset, single release, pair release, full buffer, clean with pending tags
    tbl[0]  = mv(1, 5, 0, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[1]  = mv(0, 0, 0, 0, 0, 0,  1, 5, 0, 1, 0);
    tbl[2]  = mv(0, 0, 0, 0, 0, 0,  0, 5, 0, 1, 1);
    tbl[3]  = mv(0, 0, 0, 0, 0, 0,  0, 5, 0, 1, 1);
    tbl[4]  = mv(1, 9, 1, 13, 0, 0, 0, 5, 2, 1, 0);
    tbl[5]  = mv(0, 0, 0, 0, 0, 0,  1, 9, 1, 1, 0);
    tbl[6]  = mv(0, 0, 0, 0, 0, 0,  1, 13, 0, 1, 0);
    tbl[7]  = mv(0, 0, 0, 0, 0, 0,  0, 13, 0, 1, 1);
    tbl[8]  = mv(1, 20, 1, 21, 1, 0, 0, 13, 2, 1, 0);
    tbl[9]  = mv(1, 22, 1, 23, 1, 0, 0, 13, 4, 1, 0);
    tbl[10] = mv(1, 24, 1, 25, 1, 0, 0, 13, 6, 1, 0);
    tbl[11] = mv(1, 26, 1, 27, 1, 0, 0, 13, 8, 0, 0);
    tbl[12] = mv(1, 28, 1, 29, 1, 0, 0, 13, 8, 0, 0);
    tbl[13] = mv(0, 0, 0, 0, 0, 0,  1, 20, 7, 0, 0);
    tbl[14] = mv(0, 0, 0, 0, 0, 0,  1, 21, 6, 1, 0);
    tbl[15] = mv(0, 0, 0, 0, 0, 0,  1, 22, 5, 1, 0);
    tbl[16] = mv(0, 0, 0, 0, 0, 0,  1, 23, 4, 1, 0);
    tbl[17] = mv(0, 0, 0, 0, 0, 0,  1, 24, 3, 1, 0);
    tbl[18] = mv(0, 0, 0, 0, 0, 0,  1, 25, 2, 1, 0);
    tbl[19] = mv(0, 0, 0, 0, 0, 0,  1, 26, 1, 1, 0);
    tbl[20] = mv(0, 0, 0, 0, 0, 0,  1, 27, 0, 1, 0);
    tbl[21] = mv(0, 0, 0, 0, 0, 0,  0, 27, 0, 1, 1);
    tbl[22] = mv(1, 30, 1, 31, 0, 0, 0, 27, 2, 1, 0);
    tbl[23] = mv(1, 1, 1, 2, 0, 0,  1, 30, 3, 1, 0);
    tbl[24] = mv(1, 3, 1, 4, 0, 0,  1, 31, 4, 1, 0);
    tbl[25] = mv(1, 6, 0, 0, 0, 1,  0, 31, 0, 1, 1);
    tbl[26] = mv(0, 0, 0, 0, 0, 0,  0, 31, 0, 1, 1);
    tbl[27] = mv(0, 0, 0, 0, 0, 0,  0, 31, 0, 1, 1);

    rst = 1'b1;
    #12;
    chk_all("reset", 0, 0, 0, 1, 1);
    rst = 1'b0;
    #4;

    for (int i = 0; i < NVEC; i++) begin
      drive(int'(tbl[i].v0), int'(tbl[i].t0), int'(tbl[i].v1), int'(tbl[i].t1),
            int'(tbl[i].full), int'(tbl[i].clean));
      step();
      chk_all($sformatf("vec%0d", i), int'(tbl[i].wable), int'(tbl[i].din),
              int'(tbl[i].cnt), int'(tbl[i].rdy), int'(tbl[i].emp));
    end

    // pointer wrap: 20 singles under toggling back-pressure
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || expq.size() != 0) && cyc < 200) begin
      if (sent < 20 && rel_if.RetReady) begin
        exp_tag = 5'((sent * 11) % 31 + 1);
        expq.push_back(exp_tag);
        drive(1, int'(exp_tag), 0, 0, cyc % 2, 0);
        sent++;
      end else begin
        drive(0, 0, 0, 0, cyc % 2, 0);
      end
      step();
      if (rel_if.CriqWable) begin
        if (expq.size() == 0) begin
          chk("wrap_extra_write", 1, 0);
        end else begin
          exp_tag = expq.pop_front();
          chk("wrap_order", int'(rel_if.CriqDin), int'(exp_tag));
        end
      end
      cyc++;
    end
    chk("wrap_sent", sent, 20);
    chk("wrap_leftover", expq.size(), 0);

    // tag 0 on slot0 with 17 on slot1
    drive(0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 1, 17, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (rel_if.CriqWable) got.push_back(rel_if.CriqDin);
    end
`ifdef RELQ_ZERO_FILTER_EN
    chk("zero_nwrites", got.size(), 1);
    if (got.size() > 0) chk("zero_first", int'(got[0]), 17);
`else
    chk("zero_nwrites", got.size(), 2);
    if (got.size() > 0) chk("zero_first", int'(got[0]), 0);
    if (got.size() > 1) chk("zero_second", int'(got[1]), 17);
`endif
    chk_all("zero_idle", 0, 17, 0, 1, 1);

    // asynchronous reset mid-drain
    drive(1, 8, 1, 9, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("pre_rst_wable", int'(rel_if.CriqWable), 1);
    chk("pre_rst_din", int'(rel_if.CriqDin), 8);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1, 1);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_wable", i), int'(rel_if.CriqWable), 0);
      chk($sformatf("post_rst%0d_count", i), int'(rel_if.RelCount), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
